// File: rtl/fetch_pkg.sv
// ------------------------------------------------------------------
// fetch_pkg: shared constants and state type for the fetch stage.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_C    = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR_C = 32'h0000_0000;
  localparam logic [31:0] PC_INCR        = 32'd4;
  localparam int          QUEUE_DEPTH    = 2;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
  } fetch_state_t;
`endif

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ------------------------------------------------------------------
// instr_fetch_if: ROM bus, redirect input and decode handshake.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface instr_fetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] pc_o;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_o, pc_o, instr_valid, fetch_fault,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_o, pc_o, instr_valid, fetch_fault,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

`default_nettype wire

// File: rtl/fetch_queue.sv
// ------------------------------------------------------------------
// fetch_queue: 2-entry FIFO of {instr, pc}; slot0 is always the head.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_data;
          else                 slot1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: the new word lands behind whatever remains.
          if (count_q == 2'(QUEUE_DEPTH)) begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end else begin
            slot0_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head_data = slot0_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ------------------------------------------------------------------
// instr_fetch: PC, ROM issue, redirect/squash, decode queue.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(RESET_VECTOR_C),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(NOP_INSTR_C)
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0]   pc_hold_q, pc_hold_d;
  logic                    inflight_q, inflight_d;

  logic                    redirect;
  logic                    accept;
  logic                    issue;
  logic                    valid;
  logic [2:0]              occupancy;
  logic [DATA_WIDTH-1:0]   redirect_target;
  logic [1:0]              q_count;
  logic [2*DATA_WIDTH-1:0] q_head;
  logic [DATA_WIDTH-1:0]   head_instr;
  logic [DATA_WIDTH-1:0]   head_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misaligned;
`endif

  assign {head_instr, head_pc} = q_head;

  always_comb begin
    valid           = (q_count != 2'd0);
    accept          = valid && bus.instr_ready;
    redirect_target = bus.redirect_pc & ~DATA_WIDTH'(3);
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect   = bus.redirect_valid && (state_q != FAULT);
    misaligned = redirect && !is_word_aligned(bus.redirect_pc[1:0]);
`else
    redirect   = bus.redirect_valid;
`endif
    // Count the word leaving this cycle so streaming keeps one request per cycle.
    occupancy = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, accept};
    issue     = (state_q == RUN) && !bus.redirect_valid && (occupancy < 3'd2);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = issue;
    pc_hold_d  = valid ? head_pc : pc_hold_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d    = fault_q;
`endif
    if (state_q == BOOT) state_d = RUN;
    if (issue) begin
      pc_d       = pc_q + DATA_WIDTH'(PC_INCR);
      fetch_pc_d = pc_q;
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    if (misaligned) begin
      state_d = FAULT;
      fault_d = 1'b1;
    end else if (redirect) begin
      pc_d = redirect_target;
    end
`else
    if (redirect) pc_d = redirect_target;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      fetch_pc_q <= RESET_VECTOR;
      pc_hold_q  <= RESET_VECTOR;
      inflight_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      pc_hold_q  <= pc_hold_d;
      // A redirect never issues, so the in-flight word is dropped on arrival.
      inflight_q <= inflight_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  fetch_queue #(
    .WIDTH (2*DATA_WIDTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (inflight_q && !redirect),
    .push_data ({bus.imem_rdata, fetch_pc_q}),
    .pop       (accept && !redirect),
    .head_data (q_head),
    .count     (q_count)
  );

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc_q[ADDR_WIDTH-1:0];
  assign bus.instr_valid = valid;
  assign bus.instr_o     = valid ? head_instr : NOP_INSTR;
  assign bus.pc_o        = valid ? head_pc : pc_hold_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.fetch_fault = fault_q;
`else
  assign bus.fetch_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ------------------------------------------------------------------
// tb_instr_fetch: directed stimulus plus a program-order stream model.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ROM_OFS = 32'h0000_0100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  instr_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) fif ();

  instr_fetch #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif)
  );

  always #5 clk = ~clk;

  // ROM: word at address a holds a + 0x100, returned one cycle after the request.
  always @(posedge clk) begin
    if (fif.imem_req) fif.imem_rdata <= fif.imem_addr + ROM_OFS;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stream model: the next accepted instruction is always at m_pc, and its word is m_pc + 0x100.
  logic [31:0] m_pc;
  logic        m_fault;
  logic        hold;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  initial begin
    m_pc    = 32'h0;
    m_fault = 1'b0;
    hold    = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (fif.instr_valid) begin
        chk("model_pc", fif.pc_o, m_pc);
        chk("model_instr", fif.instr_o, fif.pc_o + ROM_OFS);
      end else begin
        chk("model_nop", fif.instr_o, NOP);
      end
      chk("model_fault", 32'(fif.fetch_fault), 32'(m_fault));
      if (m_fault) chk("model_fault_quiet", 32'({fif.imem_req, fif.instr_valid}), 32'h0);
      if (fif.imem_req) chk("model_align", 32'(fif.imem_addr[1:0]), 32'h0);
      if (hold) begin
        chk("model_stall_valid", 32'(fif.instr_valid), 32'h1);
        chk("model_stall_pc", fif.pc_o, hold_pc);
        chk("model_stall_instr", fif.instr_o, hold_instr);
      end
      hold       = rst_n && fif.instr_valid && !fif.instr_ready && !fif.redirect_valid;
      hold_pc    = fif.pc_o;
      hold_instr = fif.instr_o;
      if (!rst_n) begin
        m_pc    = 32'h0;
        m_fault = 1'b0;
      end else if (!m_fault) begin
        if (fif.redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (fif.redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
          else m_pc = fif.redirect_pc & ~32'h3;
`else
          m_pc = fif.redirect_pc & ~32'h3;
`endif
        end else if (fif.instr_valid && fif.instr_ready) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    fif.instr_ready    = 1'b1;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'h0;
    rst_n = 1'b0;
    step(3);
    chk("rst_valid", 32'(fif.instr_valid), 32'h0);
    chk("rst_instr", fif.instr_o, NOP);
    chk("rst_pc", fif.pc_o, 32'h0);
    chk("rst_req", 32'(fif.imem_req), 32'h0);
    chk("rst_fault", 32'(fif.fetch_fault), 32'h0);

    // Cold start and streaming
    rst_n = 1'b1;
    step();
    chk("boot_req", 32'(fif.imem_req), 32'h1);
    chk("boot_addr", fif.imem_addr, 32'h0);
    chk("boot_valid", 32'(fif.instr_valid), 32'h0);
    step();
    chk("c2_valid", 32'(fif.instr_valid), 32'h0);
    step();
    chk("c3_valid", 32'(fif.instr_valid), 32'h1);
    chk("c3_pc", fif.pc_o, 32'h0);
    chk("c3_instr", fif.instr_o, 32'h100);
    step();
    chk("c4_pc", fif.pc_o, 32'h4);
    chk("c4_instr", fif.instr_o, 32'h104);
    step();
    chk("c5_pc", fif.pc_o, 32'h8);
    step();
    chk("c6_pc", fif.pc_o, 32'hC);
    chk("c6_instr", fif.instr_o, 32'h10C);

    // Back-pressure: two words buffered, then issue stops
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("stall_first_pc", fif.pc_o, 32'h0);
    fif.instr_ready = 1'b0;
    #1;
    chk("stall_req0", 32'(fif.imem_req), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_instr", fif.instr_o, 32'h100);
      chk("stall_req", 32'(fif.imem_req), 32'h0);
    end
    fif.instr_ready = 1'b1;
    step();
    chk("release_1", fif.instr_o, 32'h104);
    step();
    chk("release_2", fif.instr_o, 32'h108);
    step();
    chk("release_3", fif.instr_o, 32'h10C);

    // Redirect with a fetch of 0x08 in flight, a pop and a push in the same cycle
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("pre_redir_pc", fif.pc_o, 32'h4);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h40;
    #1;
    chk("redir_no_issue", 32'(fif.imem_req), 32'h0);
    step();
    fif.redirect_valid = 1'b0;
    #1;
    chk("redir_valid", 32'(fif.instr_valid), 32'h0);
    chk("redir_nop", fif.instr_o, NOP);
    chk("redir_pc_hold", fif.pc_o, 32'h4);
    chk("redir_addr", fif.imem_addr, 32'h40);
    step();
    chk("redir_c1_valid", 32'(fif.instr_valid), 32'h0);
    step();
    chk("redir_c2_pc", fif.pc_o, 32'h40);
    chk("redir_c2_instr", fif.instr_o, 32'h140);
    step();
    chk("redir_c3_pc", fif.pc_o, 32'h44);

    // PC wrap
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'hFFFF_FFFC;
    step();
    fif.redirect_valid = 1'b0;
    #1;
    chk("wrap_addr0", fif.imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", fif.imem_addr, 32'h0);
    chk("wrap_req1", 32'(fif.imem_req), 32'h1);
    step();
    chk("wrap_pc0", fif.pc_o, 32'hFFFF_FFFC);
    chk("wrap_instr0", fif.instr_o, 32'h0000_00FC);
    step();
    chk("wrap_pc1", fif.pc_o, 32'h0);

    // Misaligned redirect target
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h42;
    step();
    fif.redirect_valid = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault", 32'(fif.fetch_fault), 32'h1);
    chk("mis_req", 32'(fif.imem_req), 32'h0);
    step(4);
    chk("mis_req_late", 32'(fif.imem_req), 32'h0);
    chk("mis_fault_late", 32'(fif.fetch_fault), 32'h1);
    rst_n = 1'b0;
    step();
    chk("mis_fault_rst", 32'(fif.fetch_fault), 32'h0);
`else
    chk("mis_fault", 32'(fif.fetch_fault), 32'h0);
    chk("mis_addr", fif.imem_addr, 32'h40);
    step(2);
    chk("mis_pc", fif.pc_o, 32'h40);
`endif

    // Redirect during BOOT
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 32'h80;
    step();
    fif.redirect_valid = 1'b0;
    #1;
    chk("boot_redir_addr", fif.imem_addr, 32'h80);
    chk("boot_redir_req", 32'(fif.imem_req), 32'h1);
    step(2);
    chk("boot_redir_pc", fif.pc_o, 32'h80);
    chk("boot_redir_instr", fif.instr_o, 32'h180);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
